// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of ram_arbiter; channel i owns slice i of every packed field.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CH     = 2
);
  logic                         rdy_in;
  logic [NUM_CH-1:0]            ch_req_in;
  logic [NUM_CH-1:0]            ch_rw_in;
  logic [NUM_CH-1:0]            ch_sgn_in;
  logic [2*NUM_CH-1:0]          ch_width_in;
  logic [NUM_CH-1:0]            ch_cancel_in;
  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_in;
  logic [32*NUM_CH-1:0]         ch_wdata_in;
  logic [NUM_CH-1:0]            ch_done_out;
  logic [31:0]                  ch_rdata_out;
  logic                         busy_out;
  logic [7:0]                   ram_in;
  logic                         ram_rw_out;
  logic [ADDR_WIDTH-1:0]        ram_addr_out;
  logic [7:0]                   ram_data_out;

  modport slave (
    input  rdy_in, ch_req_in, ch_rw_in, ch_sgn_in, ch_width_in, ch_cancel_in,
           ch_addr_in, ch_wdata_in, ram_in,
    output ch_done_out, ch_rdata_out, busy_out, ram_rw_out, ram_addr_out, ram_data_out
  );

  modport master (
    output rdy_in, ch_req_in, ch_rw_in, ch_sgn_in, ch_width_in, ch_cancel_in,
           ch_addr_in, ch_wdata_in, ram_in,
    input  ch_done_out, ch_rdata_out, busy_out, ram_rw_out, ram_addr_out, ram_data_out
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of NUM_CH requesters onto one byte-wide synchronous RAM port,
// with pipelined reads, per-channel read cancel and sign/zero extension.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CH     = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  ram_arbiter_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, id_q, grant_id, scan_idx;
  logic                  grant_vld, grant, rw_q, sgn_q;
  logic                  issue_last, cancel_rd;
  logic [1:0]            n_m1_q, grant_n_m1, cap_lane;
  logic [2:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rbuf_q, assembled, extended, rdata_q;
  logic [NUM_CH-1:0]     eligible, done_q;

  // Scan from the channel after the last winner; the first eligible one wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eligible  = bus.ch_req_in & ~bus.ch_cancel_in & ~done_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      scan_idx = CH_W'((int'(rr_ptr_q) + off) % NUM_CH);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  assign grant = (state_q == IDLE) && bus.rdy_in && grant_vld;

  always_comb begin
    unique case (bus.ch_width_in[2*grant_id +: 2])
      2'b00:   grant_n_m1 = 2'd0;
      2'b01:   grant_n_m1 = 2'd1;
      default: grant_n_m1 = 2'd3;
    endcase
  end

  assign issue_last = (cnt_q == {1'b0, n_m1_q});
  assign cancel_rd  = rw_q && bus.ch_cancel_in[id_q];
  // ram_in lags the address by one cycle, so it belongs to lane cnt_q-1.
  assign cap_lane   = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   if (cancel_rd) state_d = IDLE;
               else if (issue_last) state_d = rw_q ? DRAIN : IDLE;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_rw_out   = 1'b0;
    bus.ram_addr_out = '0;
    bus.ram_data_out = 8'h00;
    if (state_q == ISSUE) begin
      bus.ram_addr_out = addr_q + ADDR_WIDTH'(cnt_q);
      bus.ram_rw_out   = ~rw_q;
      if (!rw_q) bus.ram_data_out = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  // The last byte arrives during DRAIN and is merged straight into the result.
  always_comb begin
    assembled = rbuf_q;
    assembled[{n_m1_q, 3'b000} +: 8] = bus.ram_in;
    unique case (n_m1_q)
      2'd0:    extended = {{24{sgn_q & assembled[7]}},  assembled[7:0]};
      2'd1:    extended = {{16{sgn_q & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the byte buffer is a handful of flops, not a RAM, so it is reset like the rest.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q <= CH_W'(NUM_CH - 1);
      id_q     <= '0;
      rw_q     <= 1'b0;
      sgn_q    <= 1'b0;
      n_m1_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 3'd0;
      rbuf_q   <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: if (grant) begin
          id_q     <= grant_id;
          rr_ptr_q <= grant_id;
          rw_q     <= bus.ch_rw_in[grant_id];
          sgn_q    <= bus.ch_sgn_in[grant_id];
          n_m1_q   <= grant_n_m1;
          addr_q   <= bus.ch_addr_in[ADDR_WIDTH*grant_id +: ADDR_WIDTH];
          wdata_q  <= bus.ch_wdata_in[32*grant_id +: 32];
          cnt_q    <= 3'd0;
          rbuf_q   <= '0;
        end
        ISSUE: begin
          cnt_q <= cnt_q + 3'd1;
          if (rw_q && cnt_q != 3'd0) rbuf_q[{cap_lane, 3'b000} +: 8] <= bus.ram_in;
          if (!rw_q && issue_last) done_q[id_q] <= 1'b1;
        end
        DRAIN: if (!cancel_rd) begin
          rdata_q       <= extended;
          done_q[id_q]  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_out     = (state_q != IDLE);
  assign bus.ch_done_out  = done_q;
  assign bus.ch_rdata_out = rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboarded bench for ram_arbiter: a byte-array RAM responder, a transaction-level
// reference model and a monitor that checks every issue cycle and completion.
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int NC = 2;

  typedef struct {
    int        ch;
    bit        rd;
    int        n;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit        cancel;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();
  ram_arbiter #(.ADDR_WIDTH(AW), .NUM_CH(NC)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  int        n_cmp = 0;
  int        n_fail = 0;
  int        last_ch;
  exp_t      sb_q[$];
  bit [7:0]  ram_mem [bit [31:0]];
  bit [7:0]  ref_mem [bit [31:0]];
  bit [7:0]  rd_next = 8'h00;

  function automatic bit [7:0] dflt(bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic bit [7:0] ram_rd(bit [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic bit [7:0] ref_rd(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Little-endian gather of n bytes, then sign or zero extension from bit 8n-1.
  function automatic bit [31:0] model_read(bit [31:0] addr, int n, bit sgn);
    bit [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v |= 32'(ref_rd(addr + 32'(i))) << (8 * i);
    if (sgn && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred or was missing against the expected sequence", name);
  endtask

  // RAM responder: writes land mid-cycle, read data appears just after the next edge.
  always @(negedge clk_in) begin
    if (bus.ram_rw_out) ram_mem[bus.ram_addr_out] = bus.ram_data_out;
    rd_next = ram_rd(bus.ram_addr_out);
  end

  always @(posedge clk_in) begin
    #1;
    bus.ram_in = rd_next;
  end

  // Monitor: a rising busy starts the transaction at the head of the scoreboard.
  exp_t        cur;
  bit          active = 1'b0;
  int          k = 0;
  logic [31:0] last_rd = 32'h0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      active  = 1'b0;
      last_rd = 32'h0;
    end else if (bus.busy_out) begin
      if (!active) begin
        if (sb_q.size() == 0) fail("unexpected_grant");
        else begin
          cur    = sb_q.pop_front();
          active = 1'b1;
          k      = 0;
        end
      end
      if (active) begin
        if (k < cur.n) begin
          check("ram_addr", bus.ram_addr_out, cur.addr + 32'(k));
          check("ram_rw", 32'(bus.ram_rw_out), 32'(!cur.rd));
          check("ram_data", 32'(bus.ram_data_out), cur.rd ? 32'h0 : ((cur.wdata >> (8 * k)) & 32'hFF));
        end else begin
          check("drain_addr", bus.ram_addr_out, 32'h0);
          check("drain_rw", 32'(bus.ram_rw_out), 32'h0);
        end
        k++;
      end
    end else if (active) begin
      active = 1'b0;
      if (cur.cancel) begin
        check("cancel_busy_len", 32'(k), 32'd2);
        check("cancel_no_done", 32'(bus.ch_done_out), 32'h0);
        check("cancel_rdata_kept", bus.ch_rdata_out, last_rd);
      end else begin
        check("done_channel", 32'(bus.ch_done_out), 32'h1 << cur.ch);
        check("busy_len", 32'(k), 32'(cur.rd ? cur.n + 1 : cur.n));
        if (cur.rd) begin
          check("rdata", bus.ch_rdata_out, cur.rdata);
          last_rd = cur.rdata;
        end
      end
    end else if (bus.ch_done_out != '0) begin
      fail("unexpected_done");
    end
  end

  task automatic drive(int ch, bit rd, bit sgn, bit [1:0] w, bit [31:0] addr, bit [31:0] wdata);
    bus.ch_rw_in[ch]              = rd;
    bus.ch_sgn_in[ch]             = sgn;
    bus.ch_width_in[2*ch +: 2]    = w;
    bus.ch_addr_in[AW*ch +: AW]   = addr;
    bus.ch_wdata_in[32*ch +: 32]  = wdata;
  endtask

  task automatic wait_busy(logic level, int limit, string name, output bit ok);
    int t = 0;
    do begin
      @(negedge clk_in);
      t++;
    end while (bus.busy_out !== level && t < limit);
    ok = (bus.busy_out === level);
    if (!ok) fail(name);
  endtask

  // One request from one channel; inputs are scrambled after the grant to prove latching.
  task automatic run_txn(int ch, bit rd, bit sgn, bit [1:0] w, bit [31:0] addr,
                         bit [31:0] wdata, int block_cycles, bit drop_rdy);
    exp_t e;
    bit   ok;
    e.ch     = ch;
    e.rd     = rd;
    e.n      = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    e.addr   = addr;
    e.wdata  = wdata;
    e.cancel = 1'b0;
    e.rdata  = rd ? model_read(addr, e.n, sgn) : 32'h0;
    if (!rd) for (int i = 0; i < e.n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    sb_q.push_back(e);
    drive(ch, rd, sgn, w, addr, wdata);
    if (block_cycles > 0) bus.rdy_in = 1'b0;
    bus.ch_req_in[ch] = 1'b1;
    if (block_cycles > 0) begin
      repeat (block_cycles) @(negedge clk_in);
      check("rdy_blocks_grant", 32'(bus.busy_out), 32'h0);
      bus.rdy_in = 1'b1;
    end
    wait_busy(1'b1, 20, "grant_timeout", ok);
    bus.ch_req_in[ch] = 1'b0;
    if (ok) begin
      drive(ch, 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
      if (drop_rdy) bus.rdy_in = 1'b0;
      wait_busy(1'b0, 20, "complete_timeout", ok);
    end
    bus.rdy_in = 1'b1;
    last_ch = ch;
  endtask

  // Both channels request continuously; the model predicts strict alternation.
  task automatic both_reads(int count);
    exp_t e;
    int   c, seen, t;
    c = (last_ch + 1) % NC;
    for (int i = 0; i < count; i++) begin
      e.ch = c; e.rd = 1'b1; e.cancel = 1'b0; e.wdata = 32'h0;
      if (c == 0) begin
        e.n = 4; e.addr = 32'h100; e.rdata = model_read(32'h100, 4, 1'b0);
      end else begin
        e.n = 2; e.addr = 32'h300; e.rdata = model_read(32'h300, 2, 1'b1);
      end
      sb_q.push_back(e);
      last_ch = c;
      c = (c + 1) % NC;
    end
    drive(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b1, 2'b01, 32'h300, 32'h0);
    bus.ch_req_in = '1;
    seen = 0;
    t = 0;
    while (seen < count && t < count * 12) begin
      @(negedge clk_in);
      t++;
      if (bus.ch_done_out != '0) seen++;
    end
    if (seen < count) fail("fairness_timeout");
    bus.ch_req_in = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    exp_t      e;
    bit        ok;
    int        rch;
    bit [31:0] base;

    bus.rdy_in       = 1'b1;
    bus.ch_req_in    = '0;
    bus.ch_rw_in     = '0;
    bus.ch_sgn_in    = '0;
    bus.ch_width_in  = '0;
    bus.ch_cancel_in = '0;
    bus.ch_addr_in   = '0;
    bus.ch_wdata_in  = '0;
    rst_in = 1'b1;
    foreach (ram_mem[a]) ram_mem.delete(a);
    ram_mem[32'h100] = 8'h11; ram_mem[32'h101] = 8'h22;
    ram_mem[32'h102] = 8'h33; ram_mem[32'h103] = 8'h44;
    ram_mem[32'h200] = 8'h80;
    ram_mem[32'h300] = 8'h01; ram_mem[32'h301] = 8'h80;
    ref_mem = ram_mem;

    repeat (2) @(negedge clk_in);
    check("reset_busy", 32'(bus.busy_out), 32'h0);
    check("reset_done", 32'(bus.ch_done_out), 32'h0);
    check("reset_rdata", bus.ch_rdata_out, 32'h0);
    check("reset_ram_rw", 32'(bus.ram_rw_out), 32'h0);
    check("reset_ram_addr", bus.ram_addr_out, 32'h0);
    check("reset_ram_data", 32'(bus.ram_data_out), 32'h0);
    rst_in  = 1'b0;
    last_ch = NC - 1;

    run_txn(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 0, 1'b0);
    run_txn(1, 1'b1, 1'b1, 2'b00, 32'h200, 32'h0, 0, 1'b0);
    run_txn(0, 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 0, 1'b0);
    run_txn(0, 1'b0, 1'b0, 2'b10, 32'h20, 32'hDEADBEEF, 0, 1'b0);
    run_txn(1, 1'b1, 1'b0, 2'b11, 32'h20, 32'h0, 0, 1'b0);
    run_txn(0, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 0, 1'b0);
    run_txn(1, 1'b1, 1'b1, 2'b01, 32'h301, 32'h0, 3, 1'b0);
    run_txn(0, 1'b0, 1'b0, 2'b01, 32'h40, 32'h1234ABCD, 0, 1'b1);
    both_reads(4);

    // Cancel ch1's word read in its second issue cycle while ch0 waits behind it.
    e = '{ch: 1, rd: 1'b1, n: 4, addr: 32'h100, wdata: 32'h0, rdata: 32'h0, cancel: 1'b1};
    sb_q.push_back(e);
    e = '{ch: 0, rd: 1'b1, n: 1, addr: 32'h200, wdata: 32'h0,
          rdata: model_read(32'h200, 1, 1'b1), cancel: 1'b0};
    sb_q.push_back(e);
    drive(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    bus.ch_req_in[1] = 1'b1;
    wait_busy(1'b1, 20, "cancel_grant_timeout", ok);
    bus.ch_req_in[1] = 1'b0;
    drive(0, 1'b1, 1'b1, 2'b00, 32'h200, 32'h0);
    bus.ch_req_in[0] = 1'b1;
    @(posedge clk_in); #1;
    bus.ch_cancel_in[1] = 1'b1;
    @(posedge clk_in); #1;
    bus.ch_cancel_in[1] = 1'b0;
    wait_busy(1'b1, 20, "post_cancel_grant_timeout", ok);
    bus.ch_req_in[0] = 1'b0;
    wait_busy(1'b0, 20, "post_cancel_complete_timeout", ok);
    last_ch = 0;

    for (int i = 0; i < 24; i++) begin
      rch = $urandom_range(0, NC - 1);
      case ($urandom_range(0, 3))
        0:       base = 32'h100;
        1:       base = 32'h20;
        2:       base = 32'hFFFF_FFFC;
        default: base = 32'h300;
      endcase
      run_txn(rch, 1'($urandom), 1'($urandom), 2'($urandom), base + $urandom_range(0, 7),
              $urandom, 0, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a word write clears every output asynchronously.
    e = '{ch: 0, rd: 1'b0, n: 4, addr: 32'h500, wdata: 32'hCAFEF00D, rdata: 32'h0, cancel: 1'b0};
    sb_q.push_back(e);
    drive(0, 1'b0, 1'b0, 2'b10, 32'h500, 32'hCAFEF00D);
    bus.ch_req_in[0] = 1'b1;
    wait_busy(1'b1, 20, "reset_test_grant_timeout", ok);
    bus.ch_req_in[0] = 1'b0;
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.busy_out), 32'h0);
    check("midreset_done", 32'(bus.ch_done_out), 32'h0);
    check("midreset_rdata", bus.ch_rdata_out, 32'h0);
    check("midreset_ram_rw", 32'(bus.ram_rw_out), 32'h0);
    check("midreset_ram_addr", bus.ram_addr_out, 32'h0);
    check("midreset_ram_data", 32'(bus.ram_data_out), 32'h0);
    @(negedge clk_in);
    @(posedge clk_in); #3;
    rst_in  = 1'b0;
    last_ch = NC - 1;
    both_reads(2);

    repeat (3) @(negedge clk_in);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised byte-serial memory front end that arbitrates NUM_CH requesters (instruction fetch, load/store, …) onto the single 8-bit synchronous RAM port. Each granted request is latched, so requesters need not hold inputs stable. Reads are pipelined one address per cycle. Adds round-robin fairness, per-channel read cancel and correct sign/zero extension. Sits between the core's fetch/LSU units and the RAM/IO bus.

## Interface
- ADDR_WIDTH, 32, address width
- NUM_CH, 2, number of requesting channels (≥1); channel i occupies slice i of every packed bus
- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; gates new grants only
- ch_req_in  in  NUM_CH  request level per channel
- ch_rw_in  in  NUM_CH  1 = read, 0 = write
- ch_sgn_in  in  NUM_CH  1 = sign-extend read result
- ch_width_in  in  2*NUM_CH  00 byte, 01 half, 10/11 word
- ch_cancel_in  in  NUM_CH  abort that channel's pending read
- ch_addr_in  in  NUM_CH*ADDR_WIDTH  byte address
- ch_wdata_in  in  32*NUM_CH  write data, little-endian
- ch_done_out  out  NUM_CH  one-cycle completion pulse
- ch_rdata_out  out  32  read result, shared; valid while the owning done bit is high
- busy_out  out  1  high in any non-IDLE state
- ram_in  in  8  RAM read data, valid the cycle after its address
- ram_rw_out  out  1  1 = write
- ram_addr_out  out  ADDR_WIDTH  RAM byte address
- ram_data_out  out  8  RAM write byte

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: at a posedge with rdy_in=1, eligible = req & ~cancel & ~done.
  - Pick the first eligible channel scanning from rr_ptr+1 mod NUM_CH.
  - Latch id, rw, sgn, N (1/2/4 bytes), addr, wdata; go to ISSUE with issue_cnt=0; rr_ptr<=id.
- ISSUE: drive ram_addr_out = addr+issue_cnt (mod 2^ADDR_WIDTH).
  - Writes also drive ram_rw_out=1 and ram_data_out = wdata byte issue_cnt.
  - Increment issue_cnt each posedge.
  - At the posedge where issue_cnt=N-1: write → done, go to IDLE; read → go to DRAIN.
- Read capture: the byte on ram_in during cycle k+1 belongs to the address issued in cycle k; it is stored at byte lane k.
- DRAIN: ram outputs idle; capture the last byte; set ch_rdata_out = assembled value, extended to 32 bits (sgn ? sign : zero from bit 8N-1); pulse done[id]; go to IDLE.
- Cancel: ch_cancel_in[id]=1 during a read in ISSUE/DRAIN → IDLE at the next posedge. No done; rdata unchanged. Writes ignore cancel and always complete.
- rdy_in=0 blocks grants only; an in-flight transaction runs to completion.
- Idle RAM outputs: ram_rw_out=0, ram_addr_out=0, ram_data_out=0. These are combinational from registered state.
- Reset mid-transaction aborts immediately; a partial write is accepted.
- Reset values: ch_done_out=0, ch_rdata_out=0, busy_out=0, state IDLE, rr_ptr=NUM_CH-1, so channel 0 wins first.

## Timing
- Grant posedge P0; byte i is addressed in cycle i+1.
- Read of N bytes: done high in cycle N+2 after P0 (word: 5 posedges). Busy N+1 cycles.
- Write of N bytes: done high in cycle N+1 (word: 4 posedges). Busy N cycles.
- Next grant is earliest at the posedge ending the done cycle. The completing channel is excluded at that posedge, so it must drop or renew its request.
- Back-to-back word reads from two channels: one completes every 6 cycles.

## Test plan
- Reset then word read ch0 at 0x100, RAM bytes 11 22 33 44 → addresses 0x100..0x103 on consecutive cycles, rdata 0x44332211, done[0] 5 posedges after grant.
- Signed byte read 0x80 → 0xFFFFFF80; unsigned half read 0x8001 → 0x00008001.
- Word write 0xDEADBEEF to 0x20 → rw=1 for 4 cycles, bytes EF BE AD DE to 0x20..0x23, then done.
- Both channels request continuously → grants alternate 0,1,0,1; neither is starved.
- Cancel ch1 read in its second issue cycle → no done[1], busy_out drops next cycle, ch0 is granted after.
- Read at 0xFFFFFFFE, word → addresses FE, FF, 00000000, 00000001 (wrap). Reset asserted mid-write → all outputs 0 asynchronously.
